regfile_writer: RTL and testbench
=================================

REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width.
REQ-003 The block SHALL have port clk_i, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port rsv_valid_i, input, width 1: reserve a destination at issue.
REQ-006 The block SHALL have port rsv_add_i, input, width ADDR_W: the register being reserved.
REQ-007 The block SHALL have ports alu_valid_i (input, 1), alu_add_i (input, ADDR_W), alu_dat_i (input, DATA_W) and alu_ready_o (output, 1): the ALU result channel.
REQ-008 The block SHALL have ports mem_valid_i (input, 1), mem_add_i (input, ADDR_W), mem_dat_i (input, DATA_W) and mem_ready_o (output, 1): the load result channel.
REQ-009 The block SHALL have ports w_add_o (output, ADDR_W), w_dat_o (output, DATA_W) and write_en_o (output, 1): the register file write port.
REQ-010 The block SHALL have ports chk_a_i and chk_b_i (input, ADDR_W each): the read addresses to check for hazards.
REQ-011 The block SHALL have ports busy_a_o and busy_b_o (output, 1 each): the addressed register has a write pending.
REQ-012 The block SHALL have port busy_o, output, width 32: the scoreboard busy mask.
REQ-013 The block SHALL have port error_o, output, width 1: a sticky protocol-violation flag.

Function
REQ-014 A transfer SHALL occur on a channel when valid and ready are both high at a rising clock edge.
REQ-015 Each channel SHALL have one holding register; the data SHALL load into it on the accepting edge (edge N).
REQ-016 Each channel's ready SHALL be high when its holding register is empty or is granted in the current cycle.
REQ-017 Ready SHALL depend only on internal state and SHALL never depend on valid, so the block has no combinational path from valid to ready.
REQ-018 A 2-way round-robin arbiter SHALL choose among the full holding registers each cycle.
REQ-019 When only one holding register is full, the arbiter SHALL grant it.
REQ-020 When both are full, the arbiter SHALL grant the channel not granted last time; the first conflict after reset SHALL favour mem.
REQ-021 The granted entry SHALL be registered onto w_add_o/w_dat_o at edge N+1, with write_en_o high for exactly one cycle, so the register file writes at edge N+2.
REQ-022 Throughput SHALL be one write per cycle; sustained conflicts SHALL alternate between alu and mem.
REQ-023 Address 31 is the constant-zero register: an entry addressed to 31 SHALL be accepted and drained normally, but write_en_o SHALL stay low in its output cycle.
REQ-024 An entry addressed to 31 SHALL cause no scoreboard change and no error.
REQ-025 rsv_valid_i SHALL set busy_o[rsv_add_i] at the next edge; reserving address 31 SHALL be ignored.
REQ-026 A busy bit SHALL clear at the edge on which write_en_o is high for that address, so that it clears together with the register file update.
REQ-027 When a reserve and a clear target the same register in the same cycle, the reserve SHALL win and the bit SHALL remain set.
REQ-028 busy_a_o SHALL equal busy_o[chk_a_i] and busy_b_o SHALL equal busy_o[chk_b_i], combinationally; a check of address 31 SHALL return 0.
REQ-029 error_o SHALL set and stay set until reset on either condition: reserving a register that is busy and not being cleared that cycle; or a channel accepting a non-31 address whose busy bit is 0.
REQ-030 On error, data SHALL still be written.

Reset
REQ-031 While rst_i is high at an edge, the block SHALL clear both holding registers, write_en_o, w_add_o, w_dat_o, busy_o, error_o and the round-robin pointer (pointer favouring mem).
REQ-032 alu_ready_o and mem_ready_o SHALL read 1 in the cycle after reset.
REQ-033 A reset asserted mid-operation SHALL discard buffered entries without producing a write; write_en_o SHALL be 0 in the cycle following the reset edge.

Structure
REQ-034 The package regfile_pkg SHALL hold ADDR_W, DATA_W, REG_ZERO (5'd31) and NUM_REGS (32).
REQ-035 The arbiter SHALL be a separate sub-module, rr_arbiter2, with request[1:0], grant[1:0] and a registered last-grant pointer.
REQ-036 The holding registers, scoreboard and output stage SHALL stay in regfile_writer.

Verification
REQ-037 Scenario: reserve r3; then alu_add_i=3, alu_dat_i=0xDEADBEEF is accepted at edge N -> write_en_o=1, w_add_o=3, w_dat_o=0xDEADBEEF in cycle N+1; busy_o[3]=0 after edge N+2.
REQ-038 Scenario: r4 and r5 reserved; alu(r4, 0x11) and mem(r5, 0x22) are both accepted at the same edge -> the r5 write comes first, then the r4 write; alu_ready_o=0 for exactly one cycle.
REQ-039 Scenario: alu and mem both valid continuously for 6 cycles -> the grants alternate mem, alu, mem, ...; there is never a gap cycle.
REQ-040 Scenario: mem(31, 0xFFFFFFFF) is accepted -> write_en_o stays 0, busy_o is unchanged and error_o=0.
REQ-041 Scenario: reserve r7 in the same cycle that write_en_o=1 for r7 -> busy_o[7]=1 afterwards and error_o=0; a second reserve of r7 afterwards -> error_o=1.
REQ-042 Scenario: rst_i is pulsed while both holding registers are full -> no write is produced, busy_o=0 and both ready signals are 1 in the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and register-file constants for the writeback merge path.
// Channel encoding doubles as the bit index into request/grant vectors.
package regfile_pkg;
    localparam int          ADDR_W   = 5;
    localparam int          DATA_W   = 32;
    localparam int          NUM_REGS = 32;
    localparam logic [4:0]  REG_ZERO = 5'd31;

    typedef enum logic {
        CH_ALU = 1'b0,
        CH_MEM = 1'b1
    } chan_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grant is combinational from requests, last winner is registered.
// On conflict the channel not granted last wins; reset leaves mem favoured.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] request_i,
    output logic [1:0] grant_o
);
    import regfile_pkg::*;

    chan_e last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        last_d  = last_q;
        unique case (request_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == CH_MEM) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        if (grant_o[CH_MEM]) begin
            last_d = CH_MEM;
        end else if (grant_o[CH_ALU]) begin
            last_d = CH_ALU;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= CH_ALU;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/regfile_writer.sv
// Merges ALU and load results into one register-file write port and tracks pending writes.
// One holding register per channel, write issued the edge after acceptance; ready is state-only.
module regfile_writer #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rsv_valid_i,
    input  logic [ADDR_W-1:0] rsv_add_i,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_add_i,
    input  logic [DATA_W-1:0] alu_dat_i,
    output logic              alu_ready_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_add_i,
    input  logic [DATA_W-1:0] mem_dat_i,
    output logic              mem_ready_o,
    output logic [ADDR_W-1:0] w_add_o,
    output logic [DATA_W-1:0] w_dat_o,
    output logic              write_en_o,
    input  logic [ADDR_W-1:0] chk_a_i,
    input  logic [ADDR_W-1:0] chk_b_i,
    output logic              busy_a_o,
    output logic              busy_b_o,
    output logic [31:0]       busy_o,
    output logic              error_o
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_ADD = ADDR_W'(REG_ZERO);

    logic [1:0]          full_q, full_d;
    logic [ADDR_W-1:0]   add_q [2];
    logic [ADDR_W-1:0]   add_d [2];
    logic [DATA_W-1:0]   dat_q [2];
    logic [DATA_W-1:0]   dat_d [2];
    logic [ADDR_W-1:0]   in_add [2];
    logic [DATA_W-1:0]   in_dat [2];
    logic [1:0]          vld, rdy, acc, gnt;
    logic                write_en_q, write_en_d;
    logic [ADDR_W-1:0]   w_add_q, w_add_d;
    logic [DATA_W-1:0]   w_dat_q, w_dat_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                error_q, error_d;
    chan_e               sel;

    assign vld[CH_ALU]    = alu_valid_i;
    assign vld[CH_MEM]    = mem_valid_i;
    assign in_add[CH_ALU] = alu_add_i;
    assign in_add[CH_MEM] = mem_add_i;
    assign in_dat[CH_ALU] = alu_dat_i;
    assign in_dat[CH_MEM] = mem_dat_i;

    rr_arbiter2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .request_i (full_q),
        .grant_o   (gnt)
    );

    // A slot draining this cycle can refill on the same edge, so no bubble under load.
    assign rdy = ~full_q | gnt;
    assign acc = vld & rdy;

    always_comb begin
        full_d = full_q;
        add_d  = add_q;
        dat_d  = dat_q;
        for (int c = 0; c < 2; c++) begin
            if (gnt[c]) begin
                full_d[c] = 1'b0;
            end
            if (acc[c]) begin
                full_d[c] = 1'b1;
                add_d[c]  = in_add[c];
                dat_d[c]  = in_dat[c];
            end
        end

        sel        = gnt[CH_MEM] ? CH_MEM : CH_ALU;
        write_en_d = (|gnt) && (add_q[sel] != ZERO_ADD);
        w_add_d    = (|gnt) ? add_q[sel] : w_add_q;
        w_dat_d    = (|gnt) ? dat_q[sel] : w_dat_q;

        // Clear before set so a same-cycle reserve of the retiring register keeps it busy.
        busy_d = busy_q;
        if (write_en_q) begin
            busy_d[w_add_q] = 1'b0;
        end
        if (rsv_valid_i && (rsv_add_i != ZERO_ADD)) begin
            busy_d[rsv_add_i] = 1'b1;
        end

        error_d = error_q;
        if (rsv_valid_i && (rsv_add_i != ZERO_ADD) && busy_q[rsv_add_i]
            && !(write_en_q && (w_add_q == rsv_add_i))) begin
            error_d = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            if (acc[c] && (in_add[c] != ZERO_ADD) && !busy_q[in_add[c]]) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q     <= 2'b00;
            add_q      <= '{default: '0};
            dat_q      <= '{default: '0};
            write_en_q <= 1'b0;
            w_add_q    <= '0;
            w_dat_q    <= '0;
            busy_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            full_q     <= full_d;
            add_q      <= add_d;
            dat_q      <= dat_d;
            write_en_q <= write_en_d;
            w_add_q    <= w_add_d;
            w_dat_q    <= w_dat_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign alu_ready_o = rdy[CH_ALU];
    assign mem_ready_o = rdy[CH_MEM];
    assign write_en_o  = write_en_q;
    assign w_add_o     = w_add_q;
    assign w_dat_o     = w_dat_q;
    assign busy_o      = busy_q;
    assign busy_a_o    = busy_q[chk_a_i];
    assign busy_b_o    = busy_q[chk_b_i];
    assign error_o     = error_q;
endmodule

// File: tb/tb_regfile_writer.sv
// Bench for regfile_writer: directed scenarios, a hazard-check vector table,
// and a randomized run against a transaction-level model.
module tb_regfile_writer;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          rsv_valid_i;
    logic [AW-1:0] rsv_add_i;
    logic          alu_valid_i, mem_valid_i;
    logic [AW-1:0] alu_add_i, mem_add_i;
    logic [DW-1:0] alu_dat_i, mem_dat_i;
    logic          alu_ready_o, mem_ready_o;
    logic [AW-1:0] w_add_o;
    logic [DW-1:0] w_dat_o;
    logic          write_en_o;
    logic [AW-1:0] chk_a_i, chk_b_i;
    logic          busy_a_o, busy_b_o;
    logic [31:0]   busy_o;
    logic          error_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    regfile_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rsv_valid_i (rsv_valid_i),
        .rsv_add_i   (rsv_add_i),
        .alu_valid_i (alu_valid_i),
        .alu_add_i   (alu_add_i),
        .alu_dat_i   (alu_dat_i),
        .alu_ready_o (alu_ready_o),
        .mem_valid_i (mem_valid_i),
        .mem_add_i   (mem_add_i),
        .mem_dat_i   (mem_dat_i),
        .mem_ready_o (mem_ready_o),
        .w_add_o     (w_add_o),
        .w_dat_o     (w_dat_o),
        .write_en_o  (write_en_o),
        .chk_a_i     (chk_a_i),
        .chk_b_i     (chk_b_i),
        .busy_a_o    (busy_a_o),
        .busy_b_o    (busy_b_o),
        .busy_o      (busy_o),
        .error_o     (error_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the falling edge; outputs are read there too.
    task automatic next_cycle();
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle();
        rst_i       = 1'b0;
        rsv_valid_i = 1'b0;
        rsv_add_i   = '0;
        alu_valid_i = 1'b0;
        alu_add_i   = '0;
        alu_dat_i   = '0;
        mem_valid_i = 1'b0;
        mem_add_i   = '0;
        mem_dat_i   = '0;
        chk_a_i     = '0;
        chk_b_i     = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        rsv_valid_i = 1'b1;
        rsv_add_i   = a;
        next_cycle();
        rsv_valid_i = 1'b0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    // Each channel is a one-deep slot; the port writes whichever slot the
    // round-robin rule picks, one per cycle, visible the cycle after.
    bit          m_full [2];
    logic [4:0]  m_add  [2];
    logic [31:0] m_dat  [2];
    int          m_last;
    bit          m_wen;
    logic [4:0]  m_wadd;
    logic [31:0] m_wdat;
    logic [31:0] m_busy;
    bit          m_err;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) m_full[c] = 0;
        m_last = 0;
        m_wen  = 0;
        m_wadd = '0;
        m_wdat = '0;
        m_busy = '0;
        m_err  = 0;
    endtask

    // Channel 0 = alu, 1 = mem; returns -1 when neither slot holds data.
    function automatic int model_pick();
        if (m_full[0] && m_full[1]) return 1 - m_last;
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    task automatic model_edge(input bit rv, input logic [4:0] ra,
                              input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                              input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        int          g;
        bit          take [2];
        logic [4:0]  ia [2];
        logic [31:0] id [2];
        logic [31:0] nb;
        g = model_pick();
        ia[0] = a0; ia[1] = a1; id[0] = d0; id[1] = d1;
        take[0] = v0 && (!m_full[0] || g == 0);
        take[1] = v1 && (!m_full[1] || g == 1);
        if (rv && ra != 5'd31 && m_busy[ra] && !(m_wen && m_wadd == ra)) m_err = 1;
        for (int c = 0; c < 2; c++)
            if (take[c] && ia[c] != 5'd31 && !m_busy[ia[c]]) m_err = 1;
        nb = m_busy;
        if (m_wen) nb[m_wadd] = 1'b0;
        if (rv && ra != 5'd31) nb[ra] = 1'b1;
        m_busy = nb;
        if (g >= 0) begin
            m_wen  = (m_add[g] != 5'd31);
            m_wadd = m_add[g];
            m_wdat = m_dat[g];
            m_last = g;
            m_full[g] = 0;
        end else begin
            m_wen = 0;
        end
        for (int c = 0; c < 2; c++)
            if (take[c]) begin
                m_full[c] = 1;
                m_add[c]  = ia[c];
                m_dat[c]  = id[c];
            end
    endtask

    function automatic logic [4:0] pick_busy();
        logic [4:0] cand [$];
        for (int i = 0; i < 31; i++) if (m_busy[i]) cand.push_back(5'(i));
        if (cand.size() == 0 || $urandom_range(9) == 0) return 5'd31;
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    function automatic logic [4:0] pick_free();
        logic [4:0] cand [$];
        if ($urandom_range(9) < 2) return 5'($urandom_range(31));
        for (int i = 0; i < 31; i++) if (!m_busy[i]) cand.push_back(5'(i));
        if (cand.size() == 0) return 5'd31;
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       exp_a;
        logic       exp_b;
    } chk_vec_t;

    chk_vec_t vecs [6];

    logic [31:0] exp_seq [7];
    int          alu_k, mem_k;
    logic        ra_s, rm_s;

    initial begin
        vecs[0] = '{5'd1,  5'd2,  1'b1, 1'b1};
        vecs[1] = '{5'd0,  5'd10, 1'b0, 1'b1};
        vecs[2] = '{5'd31, 5'd30, 1'b0, 1'b1};
        vecs[3] = '{5'd30, 5'd31, 1'b1, 1'b0};
        vecs[4] = '{5'd5,  5'd1,  1'b0, 1'b1};
        vecs[5] = '{5'd31, 5'd31, 1'b0, 1'b0};
        exp_seq = '{32'hB0, 32'hA0, 32'hB1, 32'hA1, 32'hB2, 32'hA2, 32'hB3};

        // Reset state
        do_reset();
        check("rst_alu_ready", alu_ready_o, 1);
        check("rst_mem_ready", mem_ready_o, 1);
        check("rst_wen", write_en_o, 0);
        check("rst_w_add", w_add_o, 0);
        check("rst_w_dat", w_dat_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_error", error_o, 0);

        // Hazard-check table, including the constant-zero register
        reserve(5'd1); reserve(5'd2); reserve(5'd10); reserve(5'd30); reserve(5'd31);
        check("tbl_busy_mask", busy_o, 32'h4000_0406);
        for (int i = 0; i < 6; i++) begin
            chk_a_i = vecs[i].a;
            chk_b_i = vecs[i].b;
            #1;
            check($sformatf("tbl_busy_a[%0d]", i), busy_a_o, vecs[i].exp_a);
            check($sformatf("tbl_busy_b[%0d]", i), busy_b_o, vecs[i].exp_b);
        end
        next_cycle();

        // Single ALU write and its scoreboard clear
        do_reset();
        reserve(5'd3);
        check("s1_busy3_set", busy_o[3], 1);
        alu_valid_i = 1'b1; alu_add_i = 5'd3; alu_dat_i = 32'hDEADBEEF;
        check("s1_alu_ready", alu_ready_o, 1);
        next_cycle();
        alu_valid_i = 1'b0;
        check("s1_no_wen_yet", write_en_o, 0);
        next_cycle();
        check("s1_wen", write_en_o, 1);
        check("s1_w_add", w_add_o, 3);
        check("s1_w_dat", w_dat_o, 32'hDEADBEEF);
        check("s1_busy3_held", busy_o[3], 1);
        next_cycle();
        check("s1_busy3_clr", busy_o[3], 0);
        check("s1_wen_pulse", write_en_o, 0);
        check("s1_error", error_o, 0);

        // Simultaneous accept: mem first after reset, alu stalls one cycle
        do_reset();
        reserve(5'd4); reserve(5'd5);
        alu_valid_i = 1'b1; alu_add_i = 5'd4; alu_dat_i = 32'h11;
        mem_valid_i = 1'b1; mem_add_i = 5'd5; mem_dat_i = 32'h22;
        next_cycle();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        check("s2_alu_stall", alu_ready_o, 0);
        check("s2_mem_ready", mem_ready_o, 1);
        next_cycle();
        check("s2_wen1", write_en_o, 1);
        check("s2_w_add1", w_add_o, 5);
        check("s2_w_dat1", w_dat_o, 32'h22);
        check("s2_alu_ready_back", alu_ready_o, 1);
        next_cycle();
        check("s2_wen2", write_en_o, 1);
        check("s2_w_add2", w_add_o, 4);
        check("s2_w_dat2", w_dat_o, 32'h11);
        next_cycle();
        check("s2_busy", busy_o, 0);
        check("s2_error", error_o, 0);

        // Sustained conflict alternates with no gap
        do_reset();
        reserve(5'd8); reserve(5'd9);
        alu_k = 0; mem_k = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid_i = 1'b1; alu_add_i = 5'd8; alu_dat_i = 32'hA0 + 32'(alu_k);
            mem_valid_i = 1'b1; mem_add_i = 5'd9; mem_dat_i = 32'hB0 + 32'(mem_k);
            ra_s = alu_ready_o; rm_s = mem_ready_o;
            next_cycle();
            if (ra_s) alu_k++;
            if (rm_s) mem_k++;
            if (c >= 1) begin
                check($sformatf("s3_wen[%0d]", c - 1), write_en_o, 1);
                check($sformatf("s3_dat[%0d]", c - 1), w_dat_o, exp_seq[c - 1]);
            end
        end
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        for (int c = 5; c < 7; c++) begin
            next_cycle();
            check($sformatf("s3_wen[%0d]", c), write_en_o, 1);
            check($sformatf("s3_dat[%0d]", c), w_dat_o, exp_seq[c]);
        end

        // Write to the zero register is drained silently
        do_reset();
        reserve(5'd2);
        mem_valid_i = 1'b1; mem_add_i = 5'd31; mem_dat_i = 32'hFFFFFFFF;
        next_cycle();
        mem_valid_i = 1'b0;
        check("s4_wen_a", write_en_o, 0);
        next_cycle();
        check("s4_wen_b", write_en_o, 0);
        check("s4_busy", busy_o, 32'h4);
        check("s4_error", error_o, 0);
        check("s4_mem_ready", mem_ready_o, 1);

        // Reserve wins over a same-cycle clear; a true double reserve flags error
        do_reset();
        reserve(5'd7);
        alu_valid_i = 1'b1; alu_add_i = 5'd7; alu_dat_i = 32'h77;
        next_cycle();
        alu_valid_i = 1'b0;
        next_cycle();
        check("s5_wen", write_en_o, 1);
        check("s5_w_add", w_add_o, 7);
        reserve(5'd7);
        check("s5_busy7", busy_o[7], 1);
        check("s5_no_error", error_o, 0);
        reserve(5'd7);
        check("s5_error_set", error_o, 1);
        next_cycle();
        check("s5_error_sticky", error_o, 1);

        // Reset with both slots full discards them
        do_reset();
        reserve(5'd4); reserve(5'd5);
        alu_valid_i = 1'b1; alu_add_i = 5'd4; alu_dat_i = 32'h44;
        mem_valid_i = 1'b1; mem_add_i = 5'd5; mem_dat_i = 32'h55;
        next_cycle();
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        check("s6_wen", write_en_o, 0);
        check("s6_busy", busy_o, 0);
        check("s6_alu_ready", alu_ready_o, 1);
        check("s6_mem_ready", mem_ready_o, 1);
        check("s6_error", error_o, 0);
        next_cycle();
        check("s6_wen_after", write_en_o, 0);

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit          r, rv, v0, v1;
            logic [4:0]  ra, a0, a1, ca, cb;
            logic [31:0] d0, d1;
            int          g;
            r  = ($urandom_range(99) < 2);
            rv = ($urandom_range(99) < 35);
            ra = pick_free();
            v0 = ($urandom_range(99) < 55);
            v1 = ($urandom_range(99) < 55);
            a0 = pick_busy();
            a1 = pick_busy();
            d0 = $urandom();
            d1 = $urandom();
            ca = 5'($urandom_range(31));
            cb = 5'($urandom_range(31));
            rst_i = r; rsv_valid_i = rv; rsv_add_i = ra;
            alu_valid_i = v0; alu_add_i = a0; alu_dat_i = d0;
            mem_valid_i = v1; mem_add_i = a1; mem_dat_i = d1;
            chk_a_i = ca; chk_b_i = cb;
            #1;
            g = model_pick();
            check("rnd_alu_ready", alu_ready_o, (!m_full[0] || g == 0));
            check("rnd_mem_ready", mem_ready_o, (!m_full[1] || g == 1));
            check("rnd_wen", write_en_o, m_wen);
            if (m_wen) begin
                check("rnd_w_add", w_add_o, m_wadd);
                check("rnd_w_dat", w_dat_o, m_wdat);
            end
            check("rnd_busy", busy_o, m_busy);
            check("rnd_error", error_o, m_err);
            check("rnd_busy_a", busy_a_o, (ca == 5'd31) ? 1'b0 : m_busy[ca]);
            check("rnd_busy_b", busy_b_o, (cb == 5'd31) ? 1'b0 : m_busy[cb]);
            if (r) model_reset();
            else   model_edge(rv, ra, v0, a0, d0, v1, a1, d1);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
